// File: rtl/sad_pe_skew_array.sv
// sad_pe_skew_array
//   Systolic 1-D array of PE_COUNT sum-of-absolute-differences engines. One
//   current-block pixel stream is compared against PE_COUNT candidate
//   reference streams; PE i works i cycles behind PE0 so that results ripple
//   out one per cycle on SAD_valid, ending with the MSB that the downstream
//   minimum comparator qualifies on.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_valid            beat valid (no backpressure)
//   in_cur_pix          current-block pixel
//   in_ref_pix          reference pixel per PE, PE i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
//   out_SAD0..15        registered SAD per PE, held until that PE's next block
//   SAD_valid           bit i pulses for one cycle when out_SADi updates
//   busy                beat counter mid-block or any beat still in the skew line
//
// The out_SADn port list is fixed at 16 entries, so PE_COUNT must stay 16.
module sad_pe_skew_array #(
  parameter int unsigned PE_COUNT       = 16,
  parameter int unsigned PIXEL_WIDTH    = 8,
  parameter int unsigned MAX_DATA_WIDTH = 16,
  parameter int unsigned BLOCK_PIXELS   = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [PIXEL_WIDTH-1:0]          in_cur_pix,
  input  logic [PE_COUNT*PIXEL_WIDTH-1:0] in_ref_pix,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD0,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD1,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD2,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD3,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD4,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD5,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD6,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD7,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD8,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD9,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD10,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD11,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD12,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD13,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD14,
  output logic [MAX_DATA_WIDTH-1:0]       out_SAD15,
  output logic [PE_COUNT-1:0]             SAD_valid,
  output logic                            busy
);

  localparam int unsigned CW = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam int unsigned D  = PE_COUNT - 1;   // depth of the shared cur/valid/last line
  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned MW = MAX_DATA_WIDTH;

  // Front-end beat counter
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(BLOCK_PIXELS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Shared skew line: stage s feeds PE s; stage 0 is the raw input.
  logic [D:1]           r_dv;
  logic [D:1]           r_dl;
  logic [PW-1:0]        r_dc [1:D];
  logic [PE_COUNT-1:0]  w_v;
  logic [PE_COUNT-1:0]  w_l;
  logic [PW-1:0]        w_c  [0:PE_COUNT-1];

  assign w_v = {r_dv, in_valid};
  assign w_l = {r_dl, in_valid & w_last};

  always_comb begin
    w_c[0] = in_cur_pix;
    for (int unsigned s = 1; s < PE_COUNT; s++) begin
      w_c[s] = r_dc[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv <= '0;
      r_dl <= '0;
    end else begin
      r_dv <= w_v[D-1:0];
      r_dl <= w_l[D-1:0];
    end
  end

  always_ff @(posedge clk) begin
    r_dc[1] <= in_cur_pix;
    for (int unsigned s = 2; s <= D; s++) begin
      r_dc[s] <= r_dc[s-1];
    end
  end

  assign busy = (r_cnt != '0) || (|r_dv);

  // Processing elements
  logic [MW-1:0] w_sad [0:PE_COUNT-1];

  for (genvar gi = 0; gi < PE_COUNT; gi++) begin : g_pe
    logic [PW-1:0] w_ref;
    logic [PW-1:0] w_diff;
    logic [MW:0]   w_sum;
    logic [MW-1:0] w_acc_next;
    logic [MW-1:0] r_acc;
    logic [MW-1:0] r_sad;
    logic          r_sv;

    // Only the reference pixel needs a private delay of gi stages.
    if (gi == 0) begin : g_nodly
      assign w_ref = in_ref_pix[0 +: PW];
    end else begin : g_dly
      logic [PW-1:0] r_rd [0:gi-1];
      always_ff @(posedge clk) begin
        r_rd[0] <= in_ref_pix[gi*PW +: PW];
        for (int unsigned j = 1; j < gi; j++) begin
          r_rd[j] <= r_rd[j-1];
        end
      end
      assign w_ref = r_rd[gi-1];
    end

    assign w_diff     = (w_c[gi] >= w_ref) ? (w_c[gi] - w_ref) : (w_ref - w_c[gi]);
    assign w_sum      = {1'b0, r_acc} + (MW+1)'(w_diff);
    // Carry out of the accumulator width clamps to all-ones instead of wrapping.
    assign w_acc_next = w_sum[MW] ? '1 : w_sum[MW-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
        r_sad <= '0;
        r_sv  <= 1'b0;
      end else begin
        r_sv <= w_v[gi] & w_l[gi];
        if (w_v[gi]) begin
          if (w_l[gi]) begin
            r_sad <= w_acc_next;
            r_acc <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
        end
      end
    end

    assign w_sad[gi]     = r_sad;
    assign SAD_valid[gi] = r_sv;
  end

  assign out_SAD0  = w_sad[0];
  assign out_SAD1  = w_sad[1];
  assign out_SAD2  = w_sad[2];
  assign out_SAD3  = w_sad[3];
  assign out_SAD4  = w_sad[4];
  assign out_SAD5  = w_sad[5];
  assign out_SAD6  = w_sad[6];
  assign out_SAD7  = w_sad[7];
  assign out_SAD8  = w_sad[8];
  assign out_SAD9  = w_sad[9];
  assign out_SAD10 = w_sad[10];
  assign out_SAD11 = w_sad[11];
  assign out_SAD12 = w_sad[12];
  assign out_SAD13 = w_sad[13];
  assign out_SAD14 = w_sad[14];
  assign out_SAD15 = w_sad[15];

endmodule

// File: tb/tb_sad_pe_skew_array.sv
module tb_sad_pe_skew_array;

  localparam int MAXC = 4096;
  typedef logic [15:0][15:0] sadvec_t;

  logic clk = 1'b0;
  logic rst;

  // Instance A: 16-beat blocks, 16-bit SADs
  logic                a_valid;
  logic [7:0]          a_cur;
  logic [127:0]        a_ref;
  logic [15:0][15:0]   a_out;
  logic [15:0]         a_sv;
  logic                a_busy;

  // Instance B: 32-beat blocks, 12-bit SADs (saturation)
  logic                b_valid;
  logic [7:0]          b_cur;
  logic [127:0]        b_ref;
  logic [15:0][11:0]   b_out;
  logic [15:0]         b_sv;
  logic                b_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-cycle observation logs, indexed by cycle number
  logic [15:0]        la_v    [0:MAXC-1];
  logic [15:0][15:0]  la_sad  [0:MAXC-1];
  logic               la_busy [0:MAXC-1];
  logic [15:0]        lb_v    [0:MAXC-1];
  logic [15:0][11:0]  lb_sad  [0:MAXC-1];

  // Behavioural reference for instance A
  int      m_acc [16];
  int      m_cnt = 0;
  int      q_last [$];
  sadvec_t q_res  [$];

  logic [7:0] zr [16];

  sad_pe_skew_array #(
    .PE_COUNT(16), .PIXEL_WIDTH(8), .MAX_DATA_WIDTH(16), .BLOCK_PIXELS(16)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_cur_pix(a_cur), .in_ref_pix(a_ref),
    .out_SAD0(a_out[0]),   .out_SAD1(a_out[1]),   .out_SAD2(a_out[2]),   .out_SAD3(a_out[3]),
    .out_SAD4(a_out[4]),   .out_SAD5(a_out[5]),   .out_SAD6(a_out[6]),   .out_SAD7(a_out[7]),
    .out_SAD8(a_out[8]),   .out_SAD9(a_out[9]),   .out_SAD10(a_out[10]), .out_SAD11(a_out[11]),
    .out_SAD12(a_out[12]), .out_SAD13(a_out[13]), .out_SAD14(a_out[14]), .out_SAD15(a_out[15]),
    .SAD_valid(a_sv), .busy(a_busy)
  );

  sad_pe_skew_array #(
    .PE_COUNT(16), .PIXEL_WIDTH(8), .MAX_DATA_WIDTH(12), .BLOCK_PIXELS(32)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_cur_pix(b_cur), .in_ref_pix(b_ref),
    .out_SAD0(b_out[0]),   .out_SAD1(b_out[1]),   .out_SAD2(b_out[2]),   .out_SAD3(b_out[3]),
    .out_SAD4(b_out[4]),   .out_SAD5(b_out[5]),   .out_SAD6(b_out[6]),   .out_SAD7(b_out[7]),
    .out_SAD8(b_out[8]),   .out_SAD9(b_out[9]),   .out_SAD10(b_out[10]), .out_SAD11(b_out[11]),
    .out_SAD12(b_out[12]), .out_SAD13(b_out[13]), .out_SAD14(b_out[14]), .out_SAD15(b_out[15]),
    .SAD_valid(b_sv), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      la_v[cyc]    = a_sv;
      la_sad[cyc]  = a_out;
      la_busy[cyc] = a_busy;
      lb_v[cyc]    = b_sv;
      lb_sad[cyc]  = b_out;
    end
  end

  // Drives one cycle on instance A and advances the reference model: a block
  // closes after 16 valid beats, its SADs are plain sums of |cur-ref|.
  task automatic drive_a(input bit v, input logic [7:0] c, input logic [7:0] r [16]);
    int      d;
    sadvec_t res;
    a_valid = v;
    a_cur   = c;
    for (int i = 0; i < 16; i++) a_ref[i*8 +: 8] = r[i];
    if (v) begin
      for (int i = 0; i < 16; i++) begin
        d = (c > r[i]) ? int'(c) - int'(r[i]) : int'(r[i]) - int'(c);
        m_acc[i] = (m_acc[i] + d > 65535) ? 65535 : m_acc[i] + d;
      end
      m_cnt++;
      if (m_cnt == 16) begin
        for (int i = 0; i < 16; i++) begin
          res[i]   = 16'(m_acc[i]);
          m_acc[i] = 0;
        end
        q_last.push_back(cyc);
        q_res.push_back(res);
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0; a_cur = '0; a_ref = '0;
    b_valid = 1'b0; b_cur = '0; b_ref = '0;
    for (int i = 0; i < 16; i++) begin zr[i] = 8'd0; m_acc[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_sv !== 16'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0", a_sv); end
    checks++; if (a_out !== '0) begin failures++; $display("FAIL reset_sad got=%h exp=0", a_out); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (b_out !== '0 || b_sv !== 16'h0) begin failures++; $display("FAIL reset_sat got=%h/%h exp=0", b_out, b_sv); end
    @(posedge clk);
    #1;
  endtask

  // Ramp block, then |50-200| and |200-50| blocks.
  task automatic test_ramp_and_abs();
    logic [7:0] r [16];
    int c0, c1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) r[i] = 8'(10 + i);
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd10, r);
    repeat (20) drive_a(1'b0, 8'd0, zr);
    for (int i = 0; i < 16; i++) r[i] = 8'd200;
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd50, r);
    repeat (20) drive_a(1'b0, 8'd0, zr);
    for (int i = 0; i < 16; i++) r[i] = 8'd50;
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd200, r);
    repeat (20) drive_a(1'b0, 8'd0, zr);
    c1 = cyc;
    for (int c = c0; c < c1; c++) begin
      logic [15:0] ev;
      ev = '0;
      for (int j = 0; j < q_last.size(); j++)
        for (int i = 0; i < 16; i++) if (c == q_last[j] + 1 + i) ev[i] = 1'b1;
      checks++;
      if (la_v[c] !== ev) begin failures++; $display("FAIL ramp_abs_valid cyc=%0d got=%h exp=%h", c, la_v[c], ev); end
      for (int j = 0; j < q_last.size(); j++)
        if (c == q_last[j] + 16)
          for (int i = 0; i < 16; i++) begin
            checks++;
            if (la_sad[c][i] !== q_res[j][i]) begin
              failures++; $display("FAIL ramp_abs_sad blk=%0d pe=%0d got=%0d exp=%0d", j, i, la_sad[c][i], q_res[j][i]);
            end
          end
    end
    q_last.delete(); q_res.delete();
  endtask

  // Ramp block with in_valid pattern 1,0,0,...; also checks busy.
  task automatic test_gaps();
    logic [7:0] r [16];
    int c0, c1, k;
    for (int i = 0; i < 16; i++) r[i] = 8'(10 + i);
    c0 = cyc;
    for (int b = 0; b < 16; b++) begin
      drive_a(1'b1, 8'd10, r);
      if (b != 15) repeat (2) drive_a(1'b0, 8'd0, zr);
    end
    repeat (24) drive_a(1'b0, 8'd0, zr);
    c1 = cyc;
    k = q_last[0];
    for (int c = c0 + 1; c <= k + 15; c++) begin
      checks++;
      if (la_busy[c] !== 1'b1) begin failures++; $display("FAIL gaps_busy_high cyc=%0d got=%b exp=1", c, la_busy[c]); end
    end
    checks++;
    if (la_busy[k + 17] !== 1'b0) begin failures++; $display("FAIL gaps_busy_low got=%b exp=0", la_busy[k + 17]); end
    for (int c = c0; c < c1; c++) begin
      logic [15:0] ev;
      ev = '0;
      for (int j = 0; j < q_last.size(); j++)
        for (int i = 0; i < 16; i++) if (c == q_last[j] + 1 + i) ev[i] = 1'b1;
      checks++;
      if (la_v[c] !== ev) begin failures++; $display("FAIL gaps_valid cyc=%0d got=%h exp=%h", c, la_v[c], ev); end
      for (int j = 0; j < q_last.size(); j++)
        if (c == q_last[j] + 16)
          for (int i = 0; i < 16; i++) begin
            checks++;
            if (la_sad[c][i] !== q_res[j][i]) begin
              failures++; $display("FAIL gaps_sad pe=%0d got=%0d exp=%0d", i, la_sad[c][i], q_res[j][i]);
            end
          end
    end
    q_last.delete(); q_res.delete();
  endtask

  // Ramp block then zero-SAD block with no gap, then random back-to-back blocks.
  task automatic test_back_to_back();
    logic [7:0] r [16];
    int c0, c1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) r[i] = 8'(10 + i);
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd10, r);
    for (int i = 0; i < 16; i++) r[i] = 8'd10;
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd10, r);
    for (int blk = 0; blk < 8; blk++) begin
      for (int b = 0; b < 16; b++) begin
        if (blk >= 4 && $urandom_range(0, 3) == 0) drive_a(1'b0, 8'd0, zr);
        for (int i = 0; i < 16; i++) r[i] = 8'($urandom_range(0, 255));
        drive_a(1'b1, 8'($urandom_range(0, 255)), r);
      end
    end
    repeat (20) drive_a(1'b0, 8'd0, zr);
    c1 = cyc;
    for (int c = c0; c < c1; c++) begin
      logic [15:0] ev;
      ev = '0;
      for (int j = 0; j < q_last.size(); j++)
        for (int i = 0; i < 16; i++) if (c == q_last[j] + 1 + i) ev[i] = 1'b1;
      checks++;
      if (la_v[c] !== ev) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%h exp=%h", c, la_v[c], ev); end
      for (int j = 0; j < q_last.size(); j++)
        if (c == q_last[j] + 16)
          for (int i = 0; i < 16; i++) begin
            checks++;
            if (la_sad[c][i] !== q_res[j][i]) begin
              failures++; $display("FAIL b2b_sad blk=%0d pe=%0d got=%0d exp=%0d", j, i, la_sad[c][i], q_res[j][i]);
            end
          end
    end
    q_last.delete(); q_res.delete();
  endtask

  // 32 beats of |0-255| into 12-bit accumulators.
  task automatic test_saturation();
    int c0, c1, kb, exp_sad;
    exp_sad = (32 * 255 > 4095) ? 4095 : 32 * 255;
    c0 = cyc;
    kb = 0;
    b_cur = 8'd0;
    b_ref = {16{8'd255}};
    for (int b = 0; b < 32; b++) begin
      b_valid = 1'b1;
      if (b == 31) kb = cyc;
      @(posedge clk);
      #1;
    end
    b_valid = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    c1 = cyc;
    for (int c = c0; c < c1; c++) begin
      logic [15:0] ev;
      ev = '0;
      for (int i = 0; i < 16; i++) if (c == kb + 1 + i) ev[i] = 1'b1;
      checks++;
      if (lb_v[c] !== ev) begin failures++; $display("FAIL sat_valid cyc=%0d got=%h exp=%h", c, lb_v[c], ev); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lb_sad[kb + 16][i] !== 12'(exp_sad)) begin
        failures++; $display("FAIL sat_sad pe=%0d got=%0d exp=%0d", i, lb_sad[kb + 16][i], exp_sad);
      end
    end
  endtask

  // Abort after beat 8 with a one-cycle reset, then a fresh ramp block.
  task automatic test_reset_mid_block();
    logic [7:0] r [16];
    int c0, c1, rc;
    c0 = cyc;
    for (int i = 0; i < 16; i++) r[i] = 8'(10 + i);
    for (int b = 0; b < 9; b++) drive_a(1'b1, 8'd10, r);
    rc = cyc;
    rst = 1'b1;
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) m_acc[i] = 0;
    repeat (20) drive_a(1'b0, 8'd0, zr);
    checks++;
    if (la_sad[rc + 1] !== '0) begin failures++; $display("FAIL rstmid_sad_zero got=%h exp=0", la_sad[rc + 1]); end
    checks++;
    if (lb_sad[rc + 1] !== '0) begin failures++; $display("FAIL rstmid_sat_zero got=%h exp=0", lb_sad[rc + 1]); end
    checks++;
    if (la_busy[rc + 1] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", la_busy[rc + 1]); end
    for (int b = 0; b < 16; b++) drive_a(1'b1, 8'd10, r);
    repeat (20) drive_a(1'b0, 8'd0, zr);
    c1 = cyc;
    for (int c = c0; c < c1; c++) begin
      logic [15:0] ev;
      ev = '0;
      for (int j = 0; j < q_last.size(); j++)
        for (int i = 0; i < 16; i++) if (c == q_last[j] + 1 + i) ev[i] = 1'b1;
      checks++;
      if (la_v[c] !== ev) begin failures++; $display("FAIL rstmid_valid cyc=%0d got=%h exp=%h", c, la_v[c], ev); end
      for (int j = 0; j < q_last.size(); j++)
        if (c == q_last[j] + 16)
          for (int i = 0; i < 16; i++) begin
            checks++;
            if (la_sad[c][i] !== q_res[j][i]) begin
              failures++; $display("FAIL rstmid_sad pe=%0d got=%0d exp=%0d", i, la_sad[c][i], q_res[j][i]);
            end
          end
    end
    q_last.delete(); q_res.delete();
  endtask

  initial begin
    test_reset();
    test_ramp_and_abs();
    test_gaps();
    test_back_to_back();
    test_saturation();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sad_pe_skew_array.md
Name: sad_pe_skew_array

Overview:
- Systolic 1D array of PE_COUNT processing elements. Each PE accumulates the sum of absolute differences (SAD) between a current-block pixel stream and one candidate reference stream.
- Produces the per-candidate SAD buses and the staggered per-PE valid vector consumed by the downstream minimum comparator. That comparator qualifies on valid MSB only, so all SAD outputs must be stable and belong to the same block while SAD_valid[PE_COUNT-1] is high.
- Sits between the search-window memory reader and the minimum comparator.

Parameters:
- PE_COUNT, 16, number of PEs / candidate positions.
- PIXEL_WIDTH, 8, unsigned pixel width.
- MAX_DATA_WIDTH, 16, SAD output width.
- BLOCK_PIXELS, 256, valid beats per block. Legal range is PE_COUNT..2^16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  current/reference beat valid.
- in_cur_pix  in  PIXEL_WIDTH  current-block pixel.
- in_ref_pix  in  PE_COUNT*PIXEL_WIDTH  reference pixel per PE; PE i uses bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- out_SAD0..out_SAD15  out  MAX_DATA_WIDTH each  registered SAD per PE.
- SAD_valid  out  PE_COUNT  bit i pulses when out_SADi is updated.
- busy  out  1  high while any beat is in flight or a block is partially accumulated.

Behaviour:
- Reset (rst high at an edge) clears:
  - the beat counter;
  - all accumulators and delay-line valid/last bits;
  - all out_SADi to 0, SAD_valid to 0, busy to 0.
- Reset mid-block discards the partial block. No SAD_valid is produced for it.
- No backpressure: every cycle with in_valid=1 is one accepted beat.
- Front-end beat counter:
  - Counts accepted beats 0..BLOCK_PIXELS-1.
  - The beat at count BLOCK_PIXELS-1 is tagged last; the counter then wraps to 0.
  - Gaps (in_valid=0) hold the counter.
- Skew:
  - PE i sees {valid, last, cur_pix, ref_pix[i]} delayed exactly i cycles from input. PE0 is undelayed.
  - Gaps propagate unchanged through the delay line.
  - Only ref_pix[i] is delayed i stages; the cur/valid/last line is PE_COUNT-1 stages deep.
- PE operation on a delayed valid beat:
  - diff = |cur - ref|, computed unsigned as the larger minus the smaller (PIXEL_WIDTH bits).
  - acc_next = acc + diff, saturating at 2^MAX_DATA_WIDTH - 1. It never wraps.
  - On a non-last beat: acc <= acc_next.
  - On the last beat: out_SADi <= acc_next, acc <= 0, and SAD_valid[i] = 1 for exactly the next cycle.
- Latency: a last beat accepted in cycle k gives SAD_valid[i] high in cycle k+1+i, so SAD_valid[PE_COUNT-1] is high in cycle k+PE_COUNT.
- Output holding:
  - out_SADi holds its value until PE i completes its next block.
  - Because BLOCK_PIXELS >= PE_COUNT, the MSB-valid cycle shows all PE_COUNT results of the same block, including with back-to-back blocks and no gaps.
- Block boundaries:
  - Back-to-back blocks are allowed. A PE may load out_SADi and start its new accumulation at 0 on consecutive beats without loss.
  - SAD_valid pulses are never merged or stretched.
- busy = (counter != 0) OR any delay-line valid bit set.
- Width rule: PIXEL_WIDTH + clog2(BLOCK_PIXELS) <= MAX_DATA_WIDTH is the normal case. Otherwise saturation applies.

Test Plan:
1. BLOCK_PIXELS=16; 16 consecutive beats with cur=10 and ref_i=10+i -> out_SADi = 16*i (0..240); SAD_valid bit i high only in cycle k+1+i, where k is the last-beat cycle.
2. BLOCK_PIXELS=16; cur=50, ref_i=200 for all i -> every out_SADi = 2400 (abs in both operand orders). Repeat with cur=200, ref=50 -> 2400.
3. Same stimulus as scenario 1, with in_valid toggling 1,0,0,1,... -> identical SAD values; SAD_valid[0] appears 1 cycle after the final valid beat; pulses stay 1 cycle apart; busy is high throughout and drops after the MSB pulse.
4. Two back-to-back blocks (block A as in scenario 1, block B with ref_i=10 so all SADs = 0), no gaps -> in the A MSB-valid cycle all outputs show A values (0..240); in the B MSB-valid cycle all outputs show 0.
5. MAX_DATA_WIDTH=12, BLOCK_PIXELS=32, cur=0, ref=255 -> all out_SADi = 4095 (saturated, not 8160 mod 4096).
6. rst asserted for 1 cycle after beat 8 of a block, followed by a fresh full block as in scenario 1 -> no SAD_valid for the aborted block; outputs read 0 after reset; the fresh block gives the scenario-1 values.
